// File: rtl/dot_result_router.sv
// dot_result_router: consumer end of the shared 9-tap dot-product datapath.
// Each issued compute slot is tagged with its phase (conv for cnt 0..66,
// fully-connected for cnt 67, bubble otherwise). The tag travels down a
// LAT-deep delay line so it meets the dot result that belongs to it.
// Conv results are ReLU'd, shifted and clamped to 8 bits. FC results are
// summed with saturation and emitted once every FC_LEN FC slots.
//
// Handshake: there is no backpressure. conv_valid and fc_valid are
// single-cycle pulses that qualify their data outputs. The data outputs
// hold their last value while the valids are low.
module dot_result_router #(
  parameter int SUM_WIDTH = 21,
  parameter int LAT       = 2,
  parameter int SHIFT     = 7,
  parameter int FC_LEN    = 16,
  parameter int ACC_WIDTH = SUM_WIDTH + 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [$clog2(69)-1:0]  cnt,
  input  logic                   clr,
  input  logic [SUM_WIDTH-1:0]   dot,
  output logic                   conv_valid,
  output logic [7:0]             conv_q,
  output logic [$clog2(69)-1:0]  conv_idx,
  output logic                   fc_valid,
  output logic [ACC_WIDTH-1:0]   fc_sum
);

  localparam int CW  = $clog2(69);
  localparam int FCW = (FC_LEN > 1) ? $clog2(FC_LEN) : 1;
  localparam logic [CW-1:0] LAST_CONV = CW'(66);
  localparam logic [CW-1:0] FC_SLOT   = CW'(67);

  // Tag delay line: one valid/fc/idx triple per pipeline stage.
  logic [LAT-1:0] r_tag_v;
  logic [LAT-1:0] r_tag_fc;
  logic [CW-1:0]  r_tag_idx [LAT];

  // FC accumulator state.
  logic [ACC_WIDTH-1:0] r_acc;
  logic [FCW-1:0]       r_fc_cnt;

  // Output registers.
  logic                 r_conv_valid;
  logic [7:0]           r_conv_q;
  logic [CW-1:0]        r_conv_idx;
  logic                 r_fc_valid;
  logic [ACC_WIDTH-1:0] r_fc_sum;

  // Tag entering this cycle: cnt 68 (and anything above) or en=0 is a bubble.
  logic w_in_v;
  logic w_in_fc;
  assign w_in_v  = en && ((cnt <= LAST_CONV) || (cnt == FC_SLOT));
  assign w_in_fc = (cnt == FC_SLOT);

  // Tag leaving the delay line this cycle; it pairs with the current dot.
  logic          w_ex_v;
  logic          w_ex_fc;
  logic [CW-1:0] w_ex_idx;
  assign w_ex_v   = r_tag_v[LAT-1];
  assign w_ex_fc  = r_tag_fc[LAT-1];
  assign w_ex_idx = r_tag_idx[LAT-1];

  // Conv requantisation: ReLU, arithmetic shift, clamp to 255.
  logic signed [SUM_WIDTH-1:0] w_shift;
  logic [7:0]                  w_conv_q;
  assign w_shift = $signed(dot) >>> SHIFT;

  // Select the 8-bit activation from the shifted dot.
  always_comb begin
    w_conv_q = w_shift[7:0];
    if (dot[SUM_WIDTH-1]) begin
      w_conv_q = 8'd0;
    end else if (|w_shift[SUM_WIDTH-1:8]) begin
      w_conv_q = 8'hFF;
    end
  end

  // FC accumulation with one guard bit to detect signed overflow.
  logic [ACC_WIDTH-1:0] w_dot_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  assign w_dot_ext = {{(ACC_WIDTH-SUM_WIDTH){dot[SUM_WIDTH-1]}}, dot};
  assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + {w_dot_ext[ACC_WIDTH-1], w_dot_ext};

  // Clamp the sum to the signed ACC_WIDTH range.
  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
      w_acc_next = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  logic w_fc_last;
  assign w_fc_last = (r_fc_cnt == FCW'(FC_LEN - 1));

  // Shift tags down the delay line; clr does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_fc <= '0;
      for (int i = 0; i < LAT; i++) r_tag_idx[i] <= '0;
    end else begin
      r_tag_v[0]   <= w_in_v;
      r_tag_fc[0]  <= w_in_fc;
      r_tag_idx[0] <= cnt;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_fc[i]  <= r_tag_fc[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // Register the conv result when a conv tag exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_valid <= 1'b0;
      r_conv_q     <= '0;
      r_conv_idx   <= '0;
    end else begin
      r_conv_valid <= 1'b0;
      if (w_ex_v && !w_ex_fc) begin
        r_conv_valid <= 1'b1;
        r_conv_q     <= w_conv_q;
        r_conv_idx   <= w_ex_idx;
      end
    end
  end

  // Accumulate FC results; clr wins over an FC tag exiting the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_fc_cnt   <= '0;
      r_fc_valid <= 1'b0;
      r_fc_sum   <= '0;
    end else begin
      r_fc_valid <= 1'b0;
      if (clr) begin
        r_acc    <= '0;
        r_fc_cnt <= '0;
      end else if (w_ex_v && w_ex_fc) begin
        if (w_fc_last) begin
          r_fc_valid <= 1'b1;
          r_fc_sum   <= w_acc_next;
          r_acc      <= '0;
          r_fc_cnt   <= '0;
        end else begin
          r_acc    <= w_acc_next;
          r_fc_cnt <= r_fc_cnt + FCW'(1);
        end
      end
    end
  end

  assign conv_valid = r_conv_valid;
  assign conv_q     = r_conv_q;
  assign conv_idx   = r_conv_idx;
  assign fc_valid   = r_fc_valid;
  assign fc_sum     = r_fc_sum;

endmodule

// File: tb/tb_dot_result_router.sv
// Bench for dot_result_router: two instances (FC_LEN 4 and 64) share one
// stimulus stream. A behavioural model tracks slot tags by cycle and
// computes every output; hand-computed literals pin the key cases.
module tb_dot_result_router;

  localparam int SW    = 21;
  localparam int LAT   = 2;
  localparam int SHIFT = 7;
  localparam int AW    = SW + 5;

  localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (AW - 1));

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [6:0]    cnt = '0;
  logic          clr = 1'b0;
  logic [SW-1:0] dot = '0;

  logic          cv0, cv1, fv0, fv1;
  logic [7:0]    cq0, cq1;
  logic [6:0]    ci0, ci1;
  logic [AW-1:0] fs0, fs1;

  always #5 clk = ~clk;

  dot_result_router #(.SUM_WIDTH(SW), .LAT(LAT), .SHIFT(SHIFT), .FC_LEN(4), .ACC_WIDTH(AW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .clr(clr), .dot(dot),
    .conv_valid(cv0), .conv_q(cq0), .conv_idx(ci0), .fc_valid(fv0), .fc_sum(fs0)
  );

  dot_result_router #(.SUM_WIDTH(SW), .LAT(LAT), .SHIFT(SHIFT), .FC_LEN(64), .ACC_WIDTH(AW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .clr(clr), .dot(dot),
    .conv_valid(cv1), .conv_q(cq1), .conv_idx(ci1), .fc_valid(fv1), .fc_sum(fs1)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int n_conv = 0;
  int n_fc0  = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the tag of each issued cycle: {live, is_fc, idx}.
  logic [8:0] exp_q[$];
  logic [8:0] t_in, t_ex;
  int         fcl [2] = '{4, 64};
  longint     m_acc [2];
  int         m_cnt [2];
  logic       e_cv;
  longint     e_cq, e_ci;
  logic       e_fv [2];
  longint     e_fs [2];
  longint     d, r, a;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = 0; m_cnt[m] = 0; e_fv[m] = 0; e_fs[m] = 0;
    end
    e_cv = 0; e_cq = 0; e_ci = 0;
  end

  // Compare process: update the model from the inputs sampled at this edge,
  // then check both DUTs just after the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      e_cv = 0; e_cq = 0; e_ci = 0;
      for (int m = 0; m < 2; m++) begin
        m_acc[m] = 0; m_cnt[m] = 0; e_fv[m] = 0; e_fs[m] = 0;
      end
    end else begin
      t_in = '0;
      if (en && cnt <= 7'd66) t_in = {1'b1, 1'b0, cnt};
      else if (en && cnt == 7'd67) t_in = {1'b1, 1'b1, 7'd0};
      exp_q.push_back(t_in);
      t_ex = '0;
      if (exp_q.size() > LAT) t_ex = exp_q.pop_front();
      d = longint'($signed(dot));
      e_cv = 0;
      if (t_ex[8] && !t_ex[7]) begin
        r = (d < 0) ? 0 : (d >>> SHIFT);
        e_cv = 1;
        e_cq = (r > 255) ? 255 : r;
        e_ci = longint'(t_ex[6:0]);
      end
      for (int m = 0; m < 2; m++) begin
        e_fv[m] = 0;
        if (clr) begin
          m_acc[m] = 0; m_cnt[m] = 0;
        end else if (t_ex[8] && t_ex[7]) begin
          a = m_acc[m] + d;
          if (a > AMAX) a = AMAX;
          if (a < AMIN) a = AMIN;
          if (m_cnt[m] == fcl[m] - 1) begin
            e_fv[m] = 1; e_fs[m] = a; m_acc[m] = 0; m_cnt[m] = 0;
          end else begin
            m_acc[m] = a; m_cnt[m]++;
          end
        end
      end
    end
    #1;
    chk("conv_valid0", cv0, e_cv);
    chk("conv_q0",     cq0, e_cq);
    chk("conv_idx0",   ci0, e_ci);
    chk("conv_valid1", cv1, e_cv);
    chk("conv_q1",     cq1, e_cq);
    chk("conv_idx1",   ci1, e_ci);
    chk("fc_valid0",   fv0, e_fv[0]);
    chk("fc_sum0",     longint'($signed(fs0)), e_fs[0]);
    chk("fc_valid1",   fv1, e_fv[1]);
    chk("fc_sum1",     longint'($signed(fs1)), e_fs[1]);
    if (cv0) n_conv++;
    if (fv0) n_fc0++;
  end

  // ---------------- driver tasks ----------------
  // Each slot carries the dot (and clr) that belongs to it; they are
  // presented LAT cycles after the slot, when its tag exits.
  logic [SW-1:0] dot_q[$];
  logic          clr_q[$];

  task automatic slot(input logic e, input int c, input int dv, input logic cl);
    en  = e;
    cnt = 7'(c);
    dot_q.push_back(SW'(dv));
    clr_q.push_back(cl);
    if (dot_q.size() > LAT) begin
      dot = dot_q.pop_front();
      clr = clr_q.pop_front();
    end else begin
      dot = '0;
      clr = 1'b0;
    end
    @(posedge clk); #2;
  endtask

  task automatic bub(input int n);
    for (int i = 0; i < n; i++) slot(1'b0, 0, 0, 1'b0);
  endtask

  task automatic fc_slot(input int dv, input logic cl);
    slot(1'b1, 67, dv, cl);
  endtask

  // ---------------- directed sequence ----------------
  int base_conv, base_fc;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_conv_valid", cv0, 0);
    chk("rst_conv_q",     cq0, 0);
    chk("rst_conv_idx",   ci0, 0);
    chk("rst_fc_valid",   fv0, 0);
    chk("rst_fc_sum",     fs0, 0);
    rst_n = 1'b1;
    bub(2);

    // Conv requantisation.
    slot(1'b1, 5, 1000, 1'b0); bub(LAT);
    chk("lit_conv_valid_1000", cv0, 1);
    chk("lit_conv_q_1000",     cq0, 7);
    chk("lit_conv_idx_5",      ci0, 5);
    slot(1'b1, 10, -500, 1'b0); bub(LAT);
    chk("lit_conv_q_neg", cq0, 0);
    chk("lit_conv_idx_10", ci0, 10);
    slot(1'b1, 66, 40000, 1'b0); bub(LAT);
    chk("lit_conv_q_sat", cq0, 255);
    bub(1);
    chk("lit_conv_hold_q", cq0, 255);

    // FC accumulation, FC_LEN=4.
    fc_slot(100, 1'b0); bub(3);
    fc_slot(200, 1'b0); bub(3);
    fc_slot(-50, 1'b0); bub(LAT);
    chk("lit_fc_no_early", fv0, 0);
    bub(1);
    fc_slot(10, 1'b0); bub(LAT);
    chk("lit_fc_valid_260", fv0, 1);
    chk("lit_fc_sum_260",   longint'($signed(fs0)), 260);
    fc_slot(1, 1'b0); fc_slot(2, 1'b0); fc_slot(3, 1'b0); fc_slot(4, 1'b0); bub(LAT);
    chk("lit_fc_sum_10", longint'($signed(fs0)), 10);

    // clr collides with the 2nd FC dot: it is dropped and the group restarts.
    fc_slot(1, 1'b0); fc_slot(2, 1'b1);
    fc_slot(5, 1'b0); fc_slot(6, 1'b0); fc_slot(7, 1'b0); bub(LAT);
    chk("lit_clr_no_valid", fv0, 0);
    fc_slot(8, 1'b0); bub(LAT);
    chk("lit_clr_valid", fv0, 1);
    chk("lit_clr_sum_26", longint'($signed(fs0)), 26);

    // Bubbles: cnt 68 and en=0 never produce a pulse.
    base_conv = n_conv; base_fc = n_fc0;
    slot(1'b1, 68, 999, 1'b0);
    slot(1'b0, 5, 999, 1'b0);
    slot(1'b0, 67, 999, 1'b0);
    bub(LAT + 1);
    chk("lit_bubble_conv", n_conv - base_conv, 0);
    chk("lit_bubble_fc",   n_fc0 - base_fc, 0);

    // One full frame: 67 conv pulses with idx 0..66.
    base_conv = n_conv;
    for (int c = 0; c < 69; c++) slot(1'b1, c, (c == 67) ? 3 : c * 128 + $urandom_range(0, 127), 1'b0);
    bub(LAT + 1);
    chk("lit_frame_pulses", n_conv - base_conv, 67);
    chk("lit_frame_last_idx", ci0, 66);

    // Saturation on the FC_LEN=64 instance.
    slot(1'b0, 0, 0, 1'b1);
    bub(LAT + 1);
    for (int i = 0; i < 64; i++) fc_slot((1 << 20) - 1, 1'b0);
    bub(LAT);
    chk("lit_sat_valid", fv1, 1);
    chk("lit_sat_sum",   longint'($signed(fs1)), (64'sd1 <<< 25) - 1);
    bub(2);

    // Asynchronous reset with tags in flight.
    for (int c = 0; c < 10; c++) slot(1'b1, c, c * 128, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_async_conv_valid", cv0, 0);
    chk("lit_async_conv_idx",   ci0, 0);
    chk("lit_async_conv_q",     cq0, 0);
    chk("lit_async_fc_sum1",    fs1, 0);
    en = 1'b0; dot = '0; clr = 1'b0;
    dot_q.delete(); clr_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    base_conv = n_conv;
    bub(LAT + 2);
    chk("lit_async_no_stray", n_conv - base_conv, 0);
    for (int c = 0; c < 69; c++) slot(1'b1, c, c * 128 + 64, 1'b0);
    bub(LAT + 1);
    chk("lit_async_frame_pulses", n_conv - base_conv, 67);
    chk("lit_async_last_q", cq0, 66);

    bub(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
